// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the UART boot loader
//
// Purpose: loader FSM state encoding and the frame sync byte value.
// Ports:   none (package).
package boot_pkg;

  typedef enum logic [2:0] {
    SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with start-glitch rejection
//
// Purpose: synchronizes the serial line, times bits from the start edge and
//          delivers one byte per frame with a stop-bit check.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_rx           asynchronous serial input, idle high
//   o_byte_valid   one-cycle pulse at the stop-bit sample
//   o_rx_byte      received byte, valid with o_byte_valid
//   o_frame_err    stop bit sampled low, valid with o_byte_valid
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_d;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte_valid <= 1'b0;
      o_rx_byte    <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_rx_d       <= r_sync2;
      o_byte_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          // Edge, not level: a line left low by a bad stop bit must not retrigger.
          if (r_rx_d && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_state <= RX_IDLE;
            end else begin
              r_state <= RX_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == FULL_M1) begin
            r_cnt        <= '0;
            r_state      <= RX_IDLE;
            o_byte_valid <= 1'b1;
            o_rx_byte    <= r_shift;
            o_frame_err  <= ~r_sync2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART program loader holding the core in reset
//
// Purpose: parses a sync/count/data frame from the UART, writes each word to
//          memory and releases the core once the whole image is written.
//          Optional trailing checksum byte is enabled by BOOT_CHECKSUM_EN.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_uart_rx      serial input, idle high, 8N1
//   o_mem_we       one-cycle memory write strobe
//   o_mem_addr     word-aligned byte address of the write
//   o_mem_wdata    word to write
//   o_core_rst_n   active-low reset to the processor core
//   o_busy         load in progress (sync accepted, not yet DONE/ERROR)
//   o_error        sticky load failure flag
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_HZ    = 12000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_core_rst_n,
  output logic        o_busy,
  output logic        o_error
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [16:0] MAX_W        = 17'(MAX_WORDS);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t ST_AFTER_LOAD = CSUM;
`else
  localparam boot_state_t ST_AFTER_LOAD = DONE;
`endif

  logic        w_byte_valid;
  logic [7:0]  w_rx_byte;
  logic        w_frame_err;
  logic [15:0] w_count;
  logic [31:0] w_word;

  boot_state_t r_state;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic [23:0] r_word;
  logic [1:0]  r_bcnt;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_uart_rx),
    .o_byte_valid (w_byte_valid),
    .o_rx_byte    (w_rx_byte),
    .o_frame_err  (w_frame_err)
  );

  assign w_count = {w_rx_byte, r_count[7:0]};
  assign w_word  = {w_rx_byte, r_word};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= SYNC;
      r_count      <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_bcnt       <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum       <= '0;
`endif
      o_mem_we     <= 1'b0;
      o_mem_addr   <= BASE_ADDR;
      o_mem_wdata  <= '0;
      o_core_rst_n <= 1'b0;
      o_busy       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_mem_we <= 1'b0;
      case (r_state)
        SYNC: begin
          if (w_byte_valid && !w_frame_err && w_rx_byte == SYNC_BYTE) begin
            r_state <= CNT_LO;
            o_busy  <= 1'b1;
          end
        end
        CNT_LO: begin
          if (w_byte_valid) begin
            if (w_frame_err) begin
              r_state <= ERROR;
            end else begin
              r_count[7:0] <= w_rx_byte;
`ifdef BOOT_CHECKSUM_EN
              r_csum       <= w_rx_byte;
`endif
              r_state      <= CNT_HI;
            end
          end
        end
        CNT_HI: begin
          if (w_byte_valid) begin
            r_count[15:8] <= w_rx_byte;
`ifdef BOOT_CHECKSUM_EN
            r_csum        <= r_csum + w_rx_byte;
`endif
            r_idx         <= '0;
            r_bcnt        <= '0;
            if (w_frame_err)                  r_state <= ERROR;
            else if (w_count == 16'd0)        r_state <= ST_AFTER_LOAD;
            else if ({1'b0, w_count} > MAX_W) r_state <= ERROR;
            else                              r_state <= DATA;
          end
        end
        DATA: begin
          if (w_byte_valid) begin
            if (w_frame_err) begin
              r_state <= ERROR;
            end else begin
              // Bytes enter at the top so byte 0 ends up in bits [7:0].
              r_word <= {w_rx_byte, r_word[23:8]};
              r_bcnt <= r_bcnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
              r_csum <= r_csum + w_rx_byte;
`endif
              if (r_bcnt == 2'd3) begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                o_mem_wdata <= w_word;
                r_idx       <= r_idx + 16'd1;
                if (r_idx + 16'd1 == r_count) r_state <= ST_AFTER_LOAD;
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: begin
          if (w_byte_valid) begin
            if (w_frame_err || w_rx_byte != r_csum) r_state <= ERROR;
            else                                     r_state <= DONE;
          end
        end
`endif
        DONE: begin
          o_core_rst_n <= 1'b1;
          o_busy       <= 1'b0;
        end
        default: begin
          // ERROR (and any unreachable encoding) is terminal until reset.
          r_state      <= ERROR;
          o_error      <= 1'b1;
          o_busy       <= 1'b0;
          o_core_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader
module tb_uart_boot_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t     exp_q[$];
  wr_t     cur;
  int      n_checks = 0;
  int      n_errs = 0;
  int      cyc = 0;
  bit      chk_release = 1'b0;
  bit      last_seen = 1'b0;
  byte_q_t fr;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLK_HZ    (1600000),
    .BAUD      (100000),
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (2048)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_uart_rx    (uart_rx),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_core_rst_n (core_rst_n),
    .o_busy       (busy),
    .o_error      (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected write whenever the DUT strobes mem_we.
  always @(negedge clk) begin
    if (last_seen) begin
      check("release_after_last_write", {31'd0, core_rst_n}, 32'd1);
      last_seen = 1'b0;
    end
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        cur = exp_q.pop_front();
        check("write_addr", mem_addr, cur.addr);
        check("write_data", mem_wdata, cur.data);
        check("core_held_during_write", {31'd0, core_rst_n}, 32'd0);
        if (exp_q.size() == 0 && chk_release) begin
          last_seen   = 1'b1;
          chk_release = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_bytes(input byte_q_t q);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0000_0000);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    chk_release = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic status(input string tag, input bit ecore, input bit ebusy, input bit eerr);
    repeat (3 * CPB) @(negedge clk);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, ecore});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, ebusy});
    check({tag, "_error"}, {31'd0, error}, {31'd0, eerr});
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic arm_release();
`ifndef BOOT_CHECKSUM_EN
    chk_release = 1'b1;
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word image.
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'hDEAD_BEEF);
    arm_release();
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("sync_busy", {31'd0, busy}, 32'd1);
    fr = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_CHECKSUM_EN
    fr.push_back(8'h4D);
`endif
    send_bytes(fr);
    status("two_word", 1'b1, 1'b0, 1'b0);

    // Leading garbage before the sync byte is ignored.
    do_reset();
    send_bytes({8'h00, 8'hFF});
    @(negedge clk);
    check("garbage_busy", {31'd0, busy}, 32'd0);
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'hDEAD_BEEF);
    arm_release();
    fr.push_front(8'hA5);
    send_bytes(fr);
    status("garbage_then_frame", 1'b1, 1'b0, 1'b0);

    // Frame error inside a word: sticky error, no writes, core held.
    do_reset();
    send_bytes({8'hA5, 8'h01, 8'h00});
    send_byte(8'h5A, 1'b0);
    status("frame_err", 1'b0, 1'b0, 1'b1);
    send_bytes({8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77});
    status("frame_err_after", 1'b0, 1'b0, 1'b1);

    // Zero-length image releases the core immediately.
    do_reset();
    fr = {8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    fr.push_back(8'h00);
`endif
    send_bytes(fr);
    status("zero_count", 1'b1, 1'b0, 1'b0);

    // Count 2049 exceeds MAX_WORDS.
    do_reset();
    send_bytes({8'hA5, 8'h01, 8'h08});
    status("count_over_max", 1'b0, 1'b0, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    push_wr(32'h0, 32'h0403_0201);
    send_bytes({8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B});
    status("csum_good", 1'b1, 1'b0, 1'b0);

    do_reset();
    push_wr(32'h0, 32'h0403_0201);
    send_bytes({8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C});
    status("csum_bad", 1'b0, 1'b0, 1'b1);
`endif

    // Reset mid-word: partial word dropped, index and address restart.
    do_reset();
    push_wr(32'h0, 32'h4433_2211);
    send_bytes({8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC});
    check("midreset_pending", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_wr(32'h0, 32'h8877_6655);
    arm_release();
    fr = {8'hA5, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef BOOT_CHECKSUM_EN
    fr.push_back(8'hBB);
`endif
    send_bytes(fr);
    status("after_midreset", 1'b1, 1'b0, 1'b0);
    if (last_seen || chk_release) begin
      n_checks++;
      n_errs++;
      $display("FAIL release_not_observed: got no release check expected one");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
